// File: rtl/float_pkg.sv
// Float format, unpack helpers and arbiter state encoding
// shared by the float write arbiter slice.
package float_pkg;

  localparam int MantissaWidth       = 23;
  localparam int BiasedExponentWidth = 8;

  typedef struct packed {
    logic                           sign;
    logic [BiasedExponentWidth-1:0] exponent;
    logic [MantissaWidth-1:0]       mantissa;
  } float_t;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_e;

  function automatic logic float_sign(float_t f);
    return f.sign;
  endfunction

  function automatic logic [MantissaWidth:0] float_significand(
    float_t f
  );
    return {|f.exponent, f.mantissa};
  endfunction

  function automatic logic [BiasedExponentWidth-1:0] float_exponent(
    float_t f
  );
    return f.exponent;
  endfunction

  function automatic logic float_is_nan(float_t f);
    return (&f.exponent) && (|f.mantissa);
  endfunction

endpackage

// File: rtl/float_write_arbiter_rr_arbiter.sv
// Round-robin priority search: first set request at or
// after ptr_i, wrapping from NumReq-1 back to 0.
module rr_arbiter #(
  parameter int NumReq = 4,
  localparam int IdxW  = (NumReq > 2) ? $clog2(NumReq) : 1
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [IdxW-1:0]   idx_o,
  output logic              vld_o
);

  // Scan from the pointer, folding indices past the top
  always_comb begin
    int            j;
    logic [IdxW-1:0] jj;
    j     = 0;
    jj    = '0;
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    for (int k = 0; k < NumReq; k++) begin
      j = int'(ptr_i) + k;
      if (j >= NumReq) j = j - NumReq;
      jj = IdxW'(j);
      if (!vld_o && req_i[jj]) begin
        vld_o     = 1'b1;
        gnt_o[jj] = 1'b1;
        idx_o     = jj;
      end
    end
  end

endmodule

// File: rtl/float_write_arbiter.sv
// Shared float register with round-robin write arbitration.
// Optional NaN drop filter: FLOAT_ARB_NAN_FILTER_EN.
module float_write_arbiter
  import float_pkg::*;
#(
  parameter int NumReq     = 4,
  parameter int HoldCycles = 0,
  localparam int IdxW      = (NumReq > 2) ? $clog2(NumReq) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NumReq-1:0]            req_valid_i,
  input  float_t [NumReq-1:0]          req_data_i,
  output logic [NumReq-1:0]            req_ready_o,
  output logic                         sign_o,
  output logic [MantissaWidth:0]       significand_o,
  output logic [BiasedExponentWidth-1:0] exponent_o,
  output logic [IdxW-1:0]              owner_o,
  output logic                         update_o,
  output logic                         busy_o
`ifdef FLOAT_ARB_NAN_FILTER_EN
  ,
  output logic                         nan_drop_o
`endif
);

  localparam logic [7:0] HoldInit =
    (HoldCycles > 0) ? 8'(HoldCycles - 1) : 8'd0;

  arb_state_e          state_q, state_d;
  logic [7:0]          hold_cnt_q;
  float_t              data_q;
  logic [IdxW-1:0]     ptr_q;
  logic [IdxW-1:0]     ptr_nxt;
  logic [NumReq-1:0]   gnt;
  logic [IdxW-1:0]     gnt_idx;
  logic                gnt_vld;
  logic                grant_en;
  logic                accept;
  logic                store;
  float_t              win_data;

  rr_arbiter #(
    .NumReq(NumReq)
  ) u_rr (
    .req_i(req_valid_i),
    .ptr_i(ptr_q),
    .gnt_o(gnt),
    .idx_o(gnt_idx),
    .vld_o(gnt_vld)
  );

  assign win_data = req_data_i[gnt_idx];
  assign accept   = grant_en & gnt_vld;
  assign ptr_nxt  = (gnt_idx == IdxW'(NumReq - 1))
                  ? '0 : gnt_idx + IdxW'(1);

`ifdef FLOAT_ARB_NAN_FILTER_EN
  logic is_nan;
  assign is_nan = float_is_nan(win_data);
  assign store  = accept & ~is_nan;
`else
  assign store  = accept;
`endif

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ARB_IDLE;
    else         state_q <= state_d;
  end

  // Next state: enter hold after a stored write, leave at count 0
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE: if (store && HoldCycles > 0) state_d = ARB_HOLD;
      ARB_HOLD: if (hold_cnt_q == 8'd0)      state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  // Outputs: grants only in idle and never while reset is held
  always_comb begin
    grant_en    = rst_ni && (state_q == ARB_IDLE);
    busy_o      = (state_q == ARB_HOLD);
    req_ready_o = grant_en ? gnt : '0;
  end

  // Hold window countdown
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_cnt_q <= 8'd0;
    end else if (state_q == ARB_IDLE && store) begin
      hold_cnt_q <= HoldInit;
    end else if (state_q == ARB_HOLD && hold_cnt_q != 8'd0) begin
      hold_cnt_q <= hold_cnt_q - 8'd1;
    end
  end

  // Stored value, owner, pointer and strobes
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q   <= '0;
      owner_o  <= '0;
      ptr_q    <= '0;
      update_o <= 1'b0;
`ifdef FLOAT_ARB_NAN_FILTER_EN
      nan_drop_o <= 1'b0;
`endif
    end else begin
      update_o <= store;
`ifdef FLOAT_ARB_NAN_FILTER_EN
      nan_drop_o <= accept & is_nan;
`endif
      if (accept) ptr_q <= ptr_nxt;
      if (store) begin
        data_q  <= win_data;
        owner_o <= gnt_idx;
      end
    end
  end

  assign sign_o        = float_sign(data_q);
  assign significand_o = float_significand(data_q);
  assign exponent_o    = float_exponent(data_q);

endmodule
